// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin access to one shared combinational ALU.
// Each requester has a valid/ready request channel. The winner's operands are
// latched onto alu_*, the ALU result is registered one cycle later and held on
// a single response channel, tagged with the requester index, until it is taken.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester handshake (req_ready one-hot)
//   req_src0/req_src1/req_op        packed per-requester payloads
//   alu_src0/alu_src1/alu_op        registered operands to the external ALU
//   alu_res                         combinational result back from the ALU
//   resp_valid/resp_ready           response handshake
//   resp_data/resp_id               registered result and owning requester
//   busy                            unit is executing or holding a response
module alu_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_src0,
    input  logic [32*NREQ-1:0]   req_src1,
    input  logic [5*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          alu_src0,
    output logic [31:0]          alu_src1,
    output logic [4:0]           alu_op,
    input  logic [31:0]          alu_res,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic [IDW-1:0]       resp_id,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]  src0_q, src0_d;
    logic [DW-1:0]  src1_q, src1_d;
    logic [OPW-1:0] op_q, op_d;
    logic           resp_valid_q, resp_valid_d;
    logic [DW-1:0]  resp_data_q, resp_data_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic           busy_q, busy_d;

    logic           arb_en;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [DW-1:0]  sel_src0;
    logic [DW-1:0]  sel_src1;
    logic [OPW-1:0] sel_op;
    logic           xfer;

    // Arbitration is open when idle, or when the held response leaves this cycle.
    assign arb_en = rstn && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));

    // Round-robin pick: first valid index at or above rr_ptr, else lowest valid below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_src0 = '0;
        sel_src1 = '0;
        sel_op   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_src0 = req_src0[DW*i +: DW];
                sel_src1 = req_src1[DW*i +: DW];
                sel_op   = req_op[OPW*i +: OPW];
            end
        end
    end

    assign xfer      = arb_en && grant_found;
    assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        src0_d       = src0_q;
        src1_d       = src1_q;
        op_d         = op_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = alu_res;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = xfer ? EXEC : IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
        endcase

        if (xfer) begin
            src0_d    = sel_src0;
            src1_d    = sel_src1;
            op_d      = sel_op;
            resp_id_d = grant_idx;
            rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            src0_q       <= '0;
            src1_q       <= '0;
            op_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            src0_q       <= src0_d;
            src1_q       <= src1_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_src0   = src0_q;
    assign alu_src1   = src1_q;
    assign alu_op     = op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLT = 5'd8;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_src0 = '0;
    logic [32*NREQ-1:0]  req_src1 = '0;
    logic [5*NREQ-1:0]   req_op = '0;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         alu_src0, alu_src1;
    logic [4:0]          alu_op;
    logic [31:0]         alu_res;
    logic                resp_valid;
    logic [31:0]         resp_data;
    logic [IDW-1:0]      resp_id;
    logic                resp_ready = 1'b0;
    logic                busy;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_src0(req_src0), .req_src1(req_src1), .req_op(req_op),
        .req_ready(req_ready),
        .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_op(alu_op), .alu_res(alu_res),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
        .resp_ready(resp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; undefined opcodes return zero.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] op);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << b[4:0];
            5'd6:    return a >> b[4:0];
            5'd7:    return $signed(a) >>> b[4:0];
            5'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res = alu_fn(alu_src0, alu_src1, alu_op);

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [4:0]  op;
        int          id;
        logic [31:0] res;
    } exp_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    exp_t sb[$];
    rsp_t rlog[$];
    int   glog[$];
    int   age = 0;
    int   ptr = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Response monitor: pops the scoreboard when a response is handed over.
    initial begin
        exp_t e;
        logic exp_rv;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sb.delete();
                age = 0;
                chk("resp_valid_in_reset", 32'(resp_valid), 32'd0);
                continue;
            end
            if (sb.size() > 0) age++;
            exp_rv = (sb.size() > 0) && (age >= 2);
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("busy", 32'(busy), 32'(sb.size() > 0));
            if (sb.size() > 0 && age >= 1) begin
                e = sb[0];
                chk("alu_src0", alu_src0, e.s0);
                chk("alu_src1", alu_src1, e.s1);
                chk("alu_op", 32'(alu_op), 32'(e.op));
            end
            if (exp_rv && resp_valid) begin
                e = sb[0];
                chk("resp_data", resp_data, e.res);
                chk("resp_id", 32'(resp_id), 32'(e.id));
                if (resp_ready) begin
                    rlog.push_back('{id: int'(resp_id), data: resp_data});
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Issue monitor: reference round-robin arbiter, pushes expected results on transfer.
    initial begin
        logic [NREQ-1:0] exp_grant;
        exp_t e;
        int g, c;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                ptr = 0;
                chk("req_ready_in_reset", 32'(req_ready), 32'd0);
                continue;
            end
            g = -1;
            if (sb.size() == 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (ptr + k) % NREQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            exp_grant = '0;
            if (g >= 0) exp_grant[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_grant));
            if (g >= 0) begin
                e.s0  = req_src0[32*g +: 32];
                e.s1  = req_src1[32*g +: 32];
                e.op  = req_op[5*g +: 5];
                e.id  = g;
                e.res = alu_fn(e.s0, e.s1, e.op);
                sb.push_back(e);
                age = 0;
                ptr = (g + 1) % NREQ;
                glog.push_back(g);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        req_valid[i]         = 1'b1;
        req_op[5*i +: 5]     = op;
        req_src0[32*i +: 32] = a;
        req_src1[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        tick(2);
        rstn = 1'b1;
        glog.delete();
        rlog.delete();
    endtask

    initial begin
        // Single op from requester 2.
        do_reset();
        resp_ready = 1'b1;
        set_req(2, OP_ADD, 32'd5, 32'd7);
        tick(1);
        req_valid = '0;
        tick(4);
        chk("t1_grants", 32'(glog.size()), 32'd1);
        chk("t1_resps", 32'(rlog.size()), 32'd1);
        if (rlog.size() == 1) begin
            chk("t1_data", rlog[0].data, 32'd12);
            chk("t1_id", 32'(rlog[0].id), 32'd2);
        end

        // Round-robin with all requesters valid.
        do_reset();
        resp_ready = 1'b1;
        set_req(0, OP_ADD, 32'd1, 32'd2);
        set_req(1, OP_SUB, 32'd3, 32'd5);
        set_req(2, OP_XOR, 32'hF0F0_0000, 32'h0FF0_0000);
        set_req(3, OP_OR, 32'h0000_0011, 32'h0000_0100);
        tick(10);
        req_valid = '0;
        tick(4);
        chk("t2_grants", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order", 32'(glog[i]), 32'(i % NREQ));
        end
        chk("t2_resps", 32'(rlog.size()), 32'd5);
        if (rlog.size() >= 2) begin
            chk("t2_sub_id", 32'(rlog[1].id), 32'd1);
            chk("t2_sub_data", rlog[1].data, 32'hFFFF_FFFE);
        end

        // Backpressure on a held SLT result.
        do_reset();
        set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        tick(1);
        req_valid = '0;
        set_req(2, OP_ADD, 32'd100, 32'd23);
        tick(6);
        resp_ready = 1'b1;
        tick(1);
        req_valid = '0;
        tick(4);
        chk("t3_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) chk("t3_second_grant", 32'(glog[1]), 32'd2);
        if (rlog.size() >= 2) begin
            chk("t3_slt_data", rlog[0].data, 32'd1);
            chk("t3_slt_id", 32'(rlog[0].id), 32'd0);
            chk("t3_add_data", rlog[1].data, 32'd123);
        end

        // Asynchronous reset while an op is executing.
        do_reset();
        resp_ready = 1'b1;
        set_req(3, OP_ADD, 32'd9, 32'd9);
        tick(1);
        req_valid = '0;
        set_req(1, OP_ADD, 32'd40, 32'd2);
        set_req(3, OP_ADD, 32'd9, 32'd9);
        #2;
        rstn = 1'b0;
        #1;
        chk("t4_alu_src0", alu_src0, 32'd0);
        chk("t4_alu_src1", alu_src1, 32'd0);
        chk("t4_alu_op", 32'(alu_op), 32'd0);
        chk("t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("t4_resp_data", resp_data, 32'd0);
        chk("t4_resp_id", 32'(resp_id), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_req_ready", 32'(req_ready), 32'd0);
        tick(2);
        rstn = 1'b1;
        tick(1);
        req_valid = '0;
        tick(4);
        chk("t4_resps", 32'(rlog.size()), 32'd1);
        if (rlog.size() == 1) begin
            chk("t4_first_id", 32'(rlog[0].id), 32'd1);
            chk("t4_first_data", rlog[0].data, 32'd42);
        end

        // Withdrawn request while a response is held.
        do_reset();
        set_req(3, OP_SRA, 32'h8000_0000, 32'd4);
        tick(1);
        req_valid = '0;
        tick(1);
        set_req(1, OP_ADD, 32'd1, 32'd1);
        tick(2);
        req_valid = '0;
        tick(1);
        resp_ready = 1'b1;
        tick(4);
        chk("t5_grants", 32'(glog.size()), 32'd1);
        chk("t5_resps", 32'(rlog.size()), 32'd1);
        if (rlog.size() == 1) begin
            chk("t5_id", 32'(rlog[0].id), 32'd3);
            chk("t5_data", rlog[0].data, 32'hF800_0000);
        end

        // Randomized traffic with random backpressure and opcodes.
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(i, 5'($urandom_range(15, 0)), $urandom(), $urandom());
                else
                    req_valid[i] = 1'b0;
            end
            resp_ready = ($urandom_range(3, 0) != 0);
            tick(1);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick(6);
        chk("rand_all_answered", 32'(rlog.size()), 32'(glog.size()));
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
